// File: rtl/encoder_stream.sv
// Purpose : streaming multi-hot to binary encoder. Each accepted vector is emitted
//           as one index per output handshake, lowest set bit first by default;
//           defining ENCODER_STREAM_MSB_FIRST_EN emits the highest set bit first.
// Latency : first index valid one cycle after acceptance; one index per cycle with out_ready high.
// Backpressure: out_ready low holds out_valid/out_idx/out_last; in_ready is low for the whole vector.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake; in_data is the N-bit multi-hot vector
//   out_valid/out_ready - output handshake; out_idx is one set-bit index, out_last marks the final one
//   zero_err            - one-cycle pulse after an all-zero vector is accepted
module encoder_stream #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 zero_err
);

  localparam int W = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           zero_err_q, zero_err_d;

  logic [W-1:0]   sel_idx;
  logic [N-1:0]   sel_mask;
  logic           sel_found;
  logic           single_bit;

  // Select the next bit to emit; the mask is used to clear it on handshake.
  always_comb begin
    sel_idx   = '0;
    sel_mask  = '0;
    sel_found = 1'b0;
`ifdef ENCODER_STREAM_MSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i] && !sel_found) begin
        sel_found   = 1'b1;
        sel_idx     = W'(i);
        sel_mask[i] = 1'b1;
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      if (pending_q[i] && !sel_found) begin
        sel_found   = 1'b1;
        sel_idx     = W'(i);
        sel_mask[i] = 1'b1;
      end
    end
`endif
  end

  // Exactly one bit left means the current index is the last, in either order.
  assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == BUSY);
  assign out_idx   = out_valid ? sel_idx : '0;
  assign out_last  = out_valid && single_bit;
  assign zero_err  = zero_err_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_data;
          if (in_data != '0) begin
            state_d = BUSY;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          pending_d = pending_q & ~sel_mask;
          // in_ready only rises the cycle after the last handshake.
          if (single_bit) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule

// File: tb/tb_encoder_stream.sv
module tb_encoder_stream;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         zero_err;

  int vectors;
  int errors;

  // Scoreboard entries: {last, idx}
  logic [W:0] sb_q[$];

  encoder_stream #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push expected output order for a vector onto the scoreboard.
  task automatic push_model(input logic [N-1:0] v);
    int remaining;
    remaining = $countones(v);
`ifdef ENCODER_STREAM_MSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) begin
`else
    for (int i = 0; i < N; i++) begin
`endif
      if (v[i]) begin
        sb_q.push_back({(remaining == 1), W'(i)});
        remaining--;
      end
    end
  endtask

  // Called between edges: offers v for exactly one rising edge.
  // With hold_garbage set, in_valid stays high with 0xFF during BUSY.
  task automatic send(input logic [N-1:0] v, input logic hold_garbage, input string tag);
    chk({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    push_model(v);
    @(posedge clk);
    #1;
    if (hold_garbage) begin
      in_data = 8'hFF;
    end else begin
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
    chk({tag, "_latency1_valid"}, 32'(out_valid), 32'(v != 0));
  endtask

  // Run until out_valid drops; returns positioned #1 after a rising edge.
  task automatic drain(input int exp_n, input string tag);
    int n;
    n = 0;
    while (out_valid === 1'b1 && n < 40) begin
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk({tag, "_cycles"}, n, exp_n);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic       stall_prev;
    logic [W:0] held;
    logic [W:0] exp_e;

    vectors   = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Output monitor: pops the scoreboard at each handshake (sampled on the falling edge).
    fork
      begin
        stall_prev = 1'b0;
        held       = '0;
        forever begin
          @(negedge clk);
          if (rst) begin
            stall_prev = 1'b0;
          end else begin
            if (stall_prev) begin
              chk("hold_valid", 32'(out_valid), 32'd1);
              chk("hold_entry", 32'({out_last, out_idx}), 32'(held));
            end
            if (!out_valid) begin
              chk("idle_idx_last", 32'({out_last, out_idx}), 32'd0);
            end else if (out_ready) begin
              if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'({out_last, out_idx}), 32'hDEAD);
              end else begin
                exp_e = sb_q.pop_front();
                chk("sb_idx", 32'(out_idx), 32'(exp_e[W-1:0]));
                chk("sb_last", 32'(out_last), 32'(exp_e[W]));
              end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_idx};
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_zero_err", 32'(zero_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // One-hot sweep, first vector on the first edge after reset release
    for (int i = 0; i < N; i++) begin
      send(8'(1 << i), 1'b0, "onehot");
      chk("onehot_idx", 32'(out_idx), i);
      chk("onehot_last", 32'(out_last), 32'd1);
      drain(1, "onehot");
    end

    // Multi-hot with garbage offered during BUSY
    send(8'b1001_0100, 1'b1, "multi");
`ifdef ENCODER_STREAM_MSB_FIRST_EN
    chk("multi_first_idx", 32'(out_idx), 32'd7);
`else
    chk("multi_first_idx", 32'(out_idx), 32'd2);
`endif
    drain(3, "multi");

    // Back-pressure
    out_ready = 1'b0;
    send(8'b0000_0110, 1'b0, "bp");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
`ifdef ENCODER_STREAM_MSB_FIRST_EN
      chk("bp_idx", 32'(out_idx), 32'd2);
`else
      chk("bp_idx", 32'(out_idx), 32'd1);
`endif
      chk("bp_last", 32'(out_last), 32'd0);
    end
    out_ready = 1'b1;
    drain(2, "bp");

    // Zero vector
    send(8'h00, 1'b0, "zero");
    chk("zero_err_pulse", 32'(zero_err), 32'd1);
    chk("zero_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("zero_err_clear", 32'(zero_err), 32'd0);
    chk("zero_no_valid", 32'(out_valid), 32'd0);

    // Reset mid-operation after the first handshake
    send(8'hFF, 1'b0, "rstmid");
    @(posedge clk);
    #1;
    chk("rstmid_busy", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_idx_last", 32'({out_last, out_idx}), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send(8'h05, 1'b0, "postrst");
    drain(2, "postrst");
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_quiet", 32'(out_valid), 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
